l2_line_arbiter: RTL and testbench
==================================

Name: l2_line_arbiter

Overview:
- Two-port arbiter placed between the L1 instruction cache and the L1 data cache, upstream of the shared 4-way L2 cache.
- Grants the single L2 read/write line interface to one L1 at a time.
- Registers the winning request and holds it stable until the L2 asserts mem_resp, then routes the response back to the winner.
- Fixed-priority policy by default; round-robin is available as a compile option.

Parameters:
- ADDR_W, 32, physical address width
- LINE_W, 256, cache line width in bits

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- i_read  in  1  I-cache line read request (level, held until i_resp)
- i_address  in  ADDR_W  I-cache line address
- i_rdata  out  LINE_W  line returned to the I-cache
- i_resp  out  1  one-cycle completion pulse to the I-cache
- d_read  in  1  D-cache line read request (level)
- d_write  in  1  D-cache line write request (level; mutually exclusive with d_read)
- d_address  in  ADDR_W  D-cache line address
- d_wdata  in  LINE_W  D-cache write line
- d_rdata  out  LINE_W  line returned to the D-cache
- d_resp  out  1  one-cycle completion pulse to the D-cache
- mem_read  out  1  read request to the L2
- mem_write  out  1  write request to the L2
- mem_address  out  ADDR_W  L2 address
- mem_wdata  out  LINE_W  L2 write line
- mem_rdata  in  LINE_W  L2 read line
- mem_resp  in  1  L2 completion

Behaviour:
- Reset (async assert, sync release): state=IDLE, last_grant=D.
  - All outputs are 0: mem_read, mem_write, i_resp, d_resp, both rdata buses, mem_address, mem_wdata.
- States: IDLE, SERVE_I, SERVE_D, RECOVER.
- IDLE:
  - If d_read or d_write is asserted, latch the D request into the registered fields (address, wdata, op) and go to SERVE_D.
  - Otherwise, if i_read is asserted, latch the I request (op=read) and go to SERVE_I.
  - Otherwise stay in IDLE.
  - No mem_* output is asserted in IDLE. Arbitration therefore costs 1 cycle.
- SERVE_x:
  - mem_read or mem_write is driven from the latched op. mem_address and mem_wdata are driven from the latched registers and stay stable for the whole state.
  - Requester inputs are ignored while in SERVE_x.
  - When mem_resp=1:
    - assert x_resp combinationally in the same cycle;
    - drive x_rdata=mem_rdata in that cycle (zero otherwise);
    - set last_grant=x;
    - go to RECOVER.
  - The non-granted requester's resp stays 0 throughout.
- RECOVER:
  - Lasts 1 cycle with no grant and no mem_* asserted, then returns to IDLE.
  - This lets the served L1 drop its level request, so the same request is never issued twice.
  - Minimum request-to-request spacing on the L2 side is therefore 2 idle cycles.
- A mem_resp arriving outside SERVE_x is ignored.
- d_read and d_write asserted together is illegal. The arbiter treats it as a write.
- A request arriving in the same cycle as mem_resp for the other requester waits until the next IDLE.
- Reset asserted mid-transaction aborts immediately:
  - no resp is issued;
  - mem_* deassert asynchronously;
  - the requester re-requests after reset.
- The L2 wait time is unbounded and there is no timeout. The arbiter waits in SERVE_x for as long as mem_resp stays low.

Optional Feature:
- Macro: L2_ARB_ROUND_ROBIN_EN.
- Defined: in IDLE with both requesters pending, grant the requester that is not last_grant. A single pending requester is granted regardless.
- Undefined: fixed D-over-I priority. last_grant is still maintained but does not affect arbitration.

Decomposition:
- Shared package l2_arb_pkg holds:
  - enum arb_state_t {IDLE, SERVE_I, SERVE_D, RECOVER};
  - enum arb_src_t {SRC_I, SRC_D};
  - struct line_req_t {op_write, address, wdata}.
- One sub-module, l2_req_latch: a line_req_t register with a load enable and async active-low clear. It is instantiated once and loaded from a mux selected by the grant.

Test Plan:
- Single I read: i_read=1, addr 0x0000_1000; L2 responds after 5 cycles with 0xA5…A5.
  - Required: mem_read high from cycle 1 to 6, with mem_address=0x1000 throughout.
  - Required: i_resp pulses in cycle 6 with i_rdata=0xA5…A5; d_resp stays 0.
- Simultaneous requests, default build: i_read at 0x2000 and d_write at 0x3000, wdata 0xDEAD…BEEF.
  - Required: D is served first, with mem_write and mem_wdata stable.
  - Required: after d_resp there is one RECOVER cycle, then an IDLE arbitration cycle, then I is served at 0x2000.
- Round-robin build: both requesters held continuously for 4 transactions.
  - Required grant order: D, I, D, I.
- Request change during service: d_address changes from 0x4000 to 0x5000 while in SERVE_D.
  - Required: mem_address stays at 0x4000 until mem_resp.
- Reset mid-transaction: rst_n is pulled low while in SERVE_I.
  - Required: mem_read goes to 0 immediately; no i_resp is issued; state=IDLE after release.
- Stray response: mem_resp=1 while in IDLE or RECOVER.
  - Required: no i_resp or d_resp, and no state change.

Source files
------------

// File: rtl/l2_arb_pkg.sv
// Shared types for the L1-to-L2 line arbiter: FSM states, requester ids and
// the registered line request that is held stable while the L2 is busy.
package l2_arb_pkg;

    localparam int L2_ADDR_W = 32;
    localparam int L2_LINE_W = 256;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D,
        RECOVER
    } arb_state_t;

    typedef enum logic {
        SRC_I,
        SRC_D
    } arb_src_t;

    typedef struct packed {
        logic                 op_write;
        logic [L2_ADDR_W-1:0] address;
        logic [L2_LINE_W-1:0] wdata;
    } line_req_t;

endpackage

// File: rtl/l2_req_latch.sv
// Holds the granted line request; loaded once per grant, cleared by reset.
module l2_req_latch
    import l2_arb_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      load_i,
    input  line_req_t req_i,
    output line_req_t req_o
);

    line_req_t req_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q <= '0;
        end else if (load_i) begin
            req_q <= req_i;
        end
    end

    assign req_o = req_q;

endmodule

// File: rtl/l2_line_arbiter.sv
// Two-port I/D line arbiter in front of the shared L2. Fixed D-over-I priority
// unless L2_ARB_ROUND_ROBIN_EN is defined, which alternates on contention.
module l2_line_arbiter
    import l2_arb_pkg::*;
#(
    parameter int ADDR_W = L2_ADDR_W,
    parameter int LINE_W = L2_LINE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    arb_state_t state_q, state_d;
    arb_src_t   last_grant_q, last_grant_d;
    arb_src_t   grant_src;
    logic       load_req;
    logic       d_pend, i_pend;
    line_req_t  req_d, req_q;

    assign d_pend = d_read | d_write;
    assign i_pend = i_read;

    always_comb begin
        grant_src = d_pend ? SRC_D : SRC_I;
`ifdef L2_ARB_ROUND_ROBIN_EN
        if (d_pend && i_pend) begin
            grant_src = (last_grant_q == SRC_D) ? SRC_I : SRC_D;
        end
`endif
    end

    // d_read together with d_write is treated as a write.
    always_comb begin
        req_d          = '0;
        req_d.op_write = (grant_src == SRC_D) && d_write;
        req_d.address  = (grant_src == SRC_D) ? L2_ADDR_W'(d_address)
                                              : L2_ADDR_W'(i_address);
        req_d.wdata    = (grant_src == SRC_D) ? L2_LINE_W'(d_wdata) : '0;
    end

    l2_req_latch u_req_latch (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (load_req),
        .req_i  (req_d),
        .req_o  (req_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= SRC_D;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        load_req     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (d_pend || i_pend) begin
                    load_req = 1'b1;
                    state_d  = (grant_src == SRC_D) ? SERVE_D : SERVE_I;
                end
            end
            SERVE_I: begin
                if (mem_resp) begin
                    last_grant_d = SRC_I;
                    state_d      = RECOVER;
                end
            end
            SERVE_D: begin
                if (mem_resp) begin
                    last_grant_d = SRC_D;
                    state_d      = RECOVER;
                end
            end
            RECOVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Everything outward is decoded from state, so reset clears it at once.
    always_comb begin
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = '0;
        mem_wdata   = '0;
        i_resp      = 1'b0;
        d_resp      = 1'b0;
        i_rdata     = '0;
        d_rdata     = '0;
        if (state_q == SERVE_I || state_q == SERVE_D) begin
            mem_read    = !req_q.op_write;
            mem_write   = req_q.op_write;
            mem_address = ADDR_W'(req_q.address);
            mem_wdata   = LINE_W'(req_q.wdata);
        end
        if (state_q == SERVE_I && mem_resp) begin
            i_resp  = 1'b1;
            i_rdata = mem_rdata;
        end
        if (state_q == SERVE_D && mem_resp) begin
            d_resp  = 1'b1;
            d_rdata = mem_rdata;
        end
    end

endmodule

// File: tb/tb_l2_line_arbiter.sv
// Directed bench for l2_line_arbiter; expectations follow the build's
// arbitration policy (L2_ARB_ROUND_ROBIN_EN selects round-robin).
module tb_l2_line_arbiter;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;
    localparam logic [LINE_W-1:0] PAT_A5   = {32{8'hA5}};
    localparam logic [LINE_W-1:0] PAT_BEEF = {8{32'hDEADBEEF}};
    localparam logic [LINE_W-1:0] PAT_55   = {32{8'h55}};
    localparam logic [LINE_W-1:0] PAT_3C   = {32{8'h3C}};

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_address;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_resp;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    l2_line_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_read      (i_read),
        .i_address   (i_address),
        .i_rdata     (i_rdata),
        .i_resp      (i_resp),
        .d_read      (d_read),
        .d_write     (d_write),
        .d_address   (d_address),
        .d_wdata     (d_wdata),
        .d_rdata     (d_rdata),
        .d_resp      (d_resp),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_resp    (mem_resp)
    );

    task automatic check_eq(input string tag, input logic [255:0] obs,
                            input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_mem_read"},  256'(mem_read),    256'(0));
        check_eq({tag, "_mem_write"}, 256'(mem_write),   256'(0));
        check_eq({tag, "_mem_addr"},  256'(mem_address), 256'(0));
        check_eq({tag, "_i_resp"},    256'(i_resp),      256'(0));
        check_eq({tag, "_d_resp"},    256'(d_resp),      256'(0));
    endtask

    initial begin
        logic exp_d;
        rst_n = 1'b0;
        i_read = 1'b0; i_address = '0;
        d_read = 1'b0; d_write = 1'b0; d_address = '0; d_wdata = '0;
        mem_rdata = '0; mem_resp = 1'b0;

        // Reset state
        #1;
        check_idle_outputs("rst");
        check_eq("rst_mem_wdata", 256'(mem_wdata), 256'(0));
        check_eq("rst_i_rdata",   256'(i_rdata),   256'(0));
        check_eq("rst_d_rdata",   256'(d_rdata),   256'(0));
        #11;
        rst_n = 1'b1;

        // Single I read, L2 answers in cycle 6
        i_read = 1'b1; i_address = 32'h0000_1000;
        step();
        for (int c = 1; c <= 5; c++) begin
            #1;
            check_eq("t1_mem_read", 256'(mem_read), 256'(1));
            check_eq("t1_mem_addr", 256'(mem_address), 256'(32'h1000));
            check_eq("t1_i_resp_early", 256'(i_resp), 256'(0));
            step();
        end
        mem_resp = 1'b1; mem_rdata = PAT_A5;
        #1;
        check_eq("t1_mem_read_c6", 256'(mem_read), 256'(1));
        check_eq("t1_i_resp", 256'(i_resp), 256'(1));
        check_eq("t1_i_rdata", 256'(i_rdata), 256'(PAT_A5));
        check_eq("t1_d_resp", 256'(d_resp), 256'(0));
        check_eq("t1_d_rdata", 256'(d_rdata), 256'(0));
        $display("txn single I read addr=1000 i_resp=%0b", i_resp);
        step();
        // Stray responses in RECOVER and IDLE
        i_read = 1'b0;
        #1;
        check_idle_outputs("stray_recover");
        check_eq("stray_recover_i_rdata", 256'(i_rdata), 256'(0));
        step();
        #1;
        check_idle_outputs("stray_idle");
        step();
        mem_resp = 1'b0;
        #1;
        check_idle_outputs("stray_after");

        // Simultaneous I read and D write: D first in both policies
        i_read = 1'b1; i_address = 32'h2000;
        d_write = 1'b1; d_address = 32'h3000; d_wdata = PAT_BEEF;
        step();
        #1;
        check_eq("t2_mem_write", 256'(mem_write), 256'(1));
        check_eq("t2_mem_read", 256'(mem_read), 256'(0));
        check_eq("t2_mem_addr", 256'(mem_address), 256'(32'h3000));
        check_eq("t2_mem_wdata", 256'(mem_wdata), 256'(PAT_BEEF));
        step();
        #1;
        check_eq("t2_mem_wdata_hold", 256'(mem_wdata), 256'(PAT_BEEF));
        mem_resp = 1'b1; mem_rdata = PAT_55;
        #1;
        check_eq("t2_d_resp", 256'(d_resp), 256'(1));
        check_eq("t2_d_rdata", 256'(d_rdata), 256'(PAT_55));
        check_eq("t2_i_resp", 256'(i_resp), 256'(0));
        check_eq("t2_i_rdata", 256'(i_rdata), 256'(0));
        $display("txn D write addr=3000 d_resp=%0b", d_resp);
        step();
        d_write = 1'b0; mem_resp = 1'b0;
        #1;
        check_idle_outputs("t2_recover");
        step();
        #1;
        check_idle_outputs("t2_arbit");
        step();
        #1;
        check_eq("t2_i_mem_read", 256'(mem_read), 256'(1));
        check_eq("t2_i_mem_addr", 256'(mem_address), 256'(32'h2000));
        mem_resp = 1'b1; mem_rdata = PAT_3C;
        #1;
        check_eq("t2_i_resp_late", 256'(i_resp), 256'(1));
        check_eq("t2_i_rdata_late", 256'(i_rdata), 256'(PAT_3C));
        $display("txn I read addr=2000 i_resp=%0b", i_resp);
        step();
        i_read = 1'b0; mem_resp = 1'b0;
        step();

        // Both held for four transactions; last grant so far is I
        d_read = 1'b1; d_address = 32'h6000;
        i_read = 1'b1; i_address = 32'h7000;
        for (int k = 0; k < 4; k++) begin
`ifdef L2_ARB_ROUND_ROBIN_EN
            exp_d = (k % 2 == 0);
`else
            exp_d = 1'b1;
`endif
            step();
            #1;
            check_eq("t3_mem_addr", 256'(mem_address),
                     exp_d ? 256'(32'h6000) : 256'(32'h7000));
            check_eq("t3_mem_read", 256'(mem_read), 256'(1));
            step();
            mem_resp = 1'b1; mem_rdata = 256'(k + 1);
            #1;
            check_eq("t3_d_resp", 256'(d_resp), 256'(exp_d));
            check_eq("t3_i_resp", 256'(i_resp), 256'(!exp_d));
            $display("txn contention #%0d granted %s", k, d_resp ? "D" : "I");
            step();
            mem_resp = 1'b0;
            #1;
            check_idle_outputs("t3_recover");
            step();
        end
        d_read = 1'b0; i_read = 1'b0;
        step();

        // D address changes while being served
        d_read = 1'b1; d_address = 32'h4000;
        step();
        d_address = 32'h5000;
        for (int c = 0; c < 3; c++) begin
            #1;
            check_eq("t4_mem_addr", 256'(mem_address), 256'(32'h4000));
            step();
        end
        mem_resp = 1'b1; mem_rdata = PAT_A5;
        #1;
        check_eq("t4_mem_addr_resp", 256'(mem_address), 256'(32'h4000));
        check_eq("t4_d_resp", 256'(d_resp), 256'(1));
        $display("txn D read addr=%0h d_resp=%0b", mem_address, d_resp);
        step();
        d_read = 1'b0; mem_resp = 1'b0;
        step();

        // Illegal d_read with d_write is a write
        d_read = 1'b1; d_write = 1'b1; d_address = 32'h9000; d_wdata = PAT_3C;
        step();
        #1;
        check_eq("t5_mem_write", 256'(mem_write), 256'(1));
        check_eq("t5_mem_read", 256'(mem_read), 256'(0));
        check_eq("t5_mem_wdata", 256'(mem_wdata), 256'(PAT_3C));
        mem_resp = 1'b1;
        #1;
        check_eq("t5_d_resp", 256'(d_resp), 256'(1));
        $display("txn D read+write addr=9000 treated as write=%0b", mem_write);
        step();
        d_read = 1'b0; d_write = 1'b0; mem_resp = 1'b0;
        step();

        // Reset while serving I
        i_read = 1'b1; i_address = 32'h8000;
        step();
        #1;
        check_eq("t6_mem_read_pre", 256'(mem_read), 256'(1));
        step();
        rst_n = 1'b0; mem_resp = 1'b1;
        #1;
        check_eq("t6_mem_read_rst", 256'(mem_read), 256'(0));
        check_eq("t6_mem_addr_rst", 256'(mem_address), 256'(0));
        check_eq("t6_i_resp_rst", 256'(i_resp), 256'(0));
        step();
        #1;
        check_eq("t6_i_resp_hold", 256'(i_resp), 256'(0));
        mem_resp = 1'b0; rst_n = 1'b1;
        #1;
        check_eq("t6_idle_after", 256'(mem_read), 256'(0));
        step();
        #1;
        check_eq("t6_rereq_read", 256'(mem_read), 256'(1));
        check_eq("t6_rereq_addr", 256'(mem_address), 256'(32'h8000));
        mem_resp = 1'b1;
        #1;
        check_eq("t6_i_resp", 256'(i_resp), 256'(1));
        $display("txn I read after reset addr=8000 i_resp=%0b", i_resp);
        step();
        i_read = 1'b0; mem_resp = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
